ascii_text_layer: RTL and testbench
===================================

ASCII_TEXT_LAYER -- requirements
Module: ascii_text_layer

Interface
REQ-001 SHALL have parameter COLS, default 16: text columns.
REQ-002 SHALL have parameter ROWS, default 4: text rows.
REQ-003 SHALL have parameter ORIGIN_X, default 0: left pixel of the text window.
REQ-004 SHALL have parameter ORIGIN_Y, default 0: top pixel of the text window.
REQ-005 SHALL have parameter SCALE, default 1: glyph magnification; legal values are 1, 2 and 4.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: character write strobe.
REQ-009 SHALL have port wr_col, input, clog2(COLS) bits: write column.
REQ-010 SHALL have port wr_row, input, clog2(ROWS) bits: write row.
REQ-011 SHALL have port wr_char, input, 7 bits: ASCII code to store.
REQ-012 SHALL have ports x and y, input, 10 bits each: current pixel coordinate.
REQ-013 SHALL have port video_on, input, 1 bit: the coordinate is in the active area.
REQ-014 SHALL have port pixel_out, output, 1 bit: foreground bit.
REQ-015 SHALL have port pixel_valid, output, 1 bit: video_on delayed to align with pixel_out.
REQ-016 SHALL have port busy, output, 1 bit: buffer clear in progress.

Function
REQ-017 SHALL hold a COLS x ROWS character buffer of 7-bit codes, written when wr_en=1 and busy=0; wr_en SHALL be ignored while busy=1.
REQ-018 SHALL ignore any write whose wr_col >= COLS or wr_row >= ROWS.
REQ-019 SHALL give each cell 8*SCALE x 16*SCALE pixels; the window SHALL span ORIGIN_X..ORIGIN_X+8*SCALE*COLS-1 and ORIGIN_Y..ORIGIN_Y+16*SCALE*ROWS-1.
REQ-020 SHALL compute, inside the window, cell column = (x-ORIGIN_X)/(8*SCALE), glyph bit = ((x-ORIGIN_X)/SCALE) mod 8, cell row = (y-ORIGIN_Y)/(16*SCALE), and glyph row = ((y-ORIGIN_Y)/SCALE) mod 16; all divisions SHALL be shifts.
REQ-021 SHALL treat glyph bit 0 as the MSB (leftmost pixel) of the glyph row byte.
REQ-022 SHALL use a three-stage pipeline: stage 1 registers coordinates, window flag and video_on; stage 2 reads the buffer; stage 3 reads the glyph and selects the bit.
REQ-023 SHALL drive pixel_out and pixel_valid at cycle t+3 for inputs sampled at cycle t, with a fixed latency of 3 and no bubbles.
REQ-024 SHALL output pixel_out=0 when the pixel is outside the window, when video_on=0, or when busy=1.
REQ-025 SHALL provide patterned glyphs for codes 0x30-0x39 (the digits, 8x16, rows 0-1 and 12-15 blank); all other codes SHALL render blank.
REQ-026 SHALL, when a write and a pipeline read hit the same cell in the same cycle, return the old content to the read (read-first); the new content SHALL be visible from the next cycle.
REQ-027 SHALL implement an FSM with states CLEAR and RUN; CLEAR SHALL write 0x20 to one cell per cycle in linear order (row*COLS+col) and move to RUN after cell COLS*ROWS-1.
REQ-028 SHALL assert busy=1 exactly in CLEAR, i.e. for COLS*ROWS cycles after reset is released.

Reset
REQ-029 SHALL, on reset=1, enter CLEAR with the clear counter at 0, and clear pixel_out, pixel_valid and all pipeline valid flags to 0; busy SHALL read 1.
REQ-030 SHALL, when reset is asserted mid-clear or mid-frame, restart the clear from cell 0; no partial pixel output SHALL be emitted.

Structure
REQ-031 SHALL place GLYPH_W=8, GLYPH_H=16, CHAR_BLANK=7'h20 and the FSM state encoding in the shared package text_layer_pkg.
REQ-032 SHALL implement the glyph store as sub-module glyph_rom: {code[6:0], row[3:0]} address, registered read, 8-bit data, inferred as block ROM.

Verification (COLS=16, ROWS=4, ORIGIN=0, SCALE=1 unless stated)
REQ-033 SHALL check: release reset -> busy high for exactly 64 cycles; then scan the full window -> pixel_out always 0.
REQ-034 SHALL check: write 0x30 at (0,0); drive y=2, x=0..7 with video_on=1 -> pixel_out 0,0,1,1,1,0,0,0 starting 3 cycles later, and pixel_valid=1 throughout.
REQ-035 SHALL check: write 0x41 at (1,0) and scan y=5, x=8..15 -> all 0; drive x=128, y=5 -> 0.
REQ-036 SHALL check: wr_en with 0x31 during busy -> ignored, cell still blank after the clear completes.
REQ-037 SHALL check: in the same cycle that stage 2 reads cell (0,0), write 0x31 to (0,0) -> old glyph for that pixel, new glyph for the following pixel.
REQ-038 SHALL check: with SCALE=2, 0x31 at (0,0), y=4..5, x=0..15 -> row byte 00011000 with each bit repeated twice horizontally and on both lines.

Source files
------------

// File: rtl/text_layer_pkg.sv
// Shared constants and FSM encoding for the ASCII text overlay.
package text_layer_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam logic [6:0] CHAR_BLANK = 7'h20;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/ascii_text_layer_glyph_rom.sv
// 8x16 glyph store: digits 0-9 patterned on rows 2..11, every other code blank.
module glyph_rom
    import text_layer_pkg::*;
(
    input  logic               clk,
    input  logic [10:0]        addr,
    output logic [GLYPH_W-1:0] data
);

    // Rows 2..11 of each digit, first byte is glyph row 2, MSB is leftmost pixel.
    localparam logic [79:0] DIGITS [10] = '{
        80'h38_44_44_4C_54_64_44_44_44_38,
        80'h18_38_18_18_18_18_18_18_18_7E,
        80'h3C_42_02_04_08_10_20_40_40_7E,
        80'h3C_42_02_02_1C_02_02_02_42_3C,
        80'h04_0C_14_24_44_7E_04_04_04_04,
        80'h7E_40_40_7C_02_02_02_02_42_3C,
        80'h3C_40_40_7C_42_42_42_42_42_3C,
        80'h7E_02_04_04_08_08_10_10_10_10,
        80'h3C_42_42_42_3C_42_42_42_42_3C,
        80'h3C_42_42_42_3E_02_02_02_04_38
    };

    function automatic logic [GLYPH_W-1:0] lookup(input logic [10:0] a);
        logic [6:0] code;
        logic [3:0] row;
        logic [3:0] r;
        code   = a[10:4];
        row    = a[3:0];
        r      = row - 4'd2;
        lookup = '0;
        if (code >= 7'h30 && code <= 7'h39 && row >= 4'd2 && row <= 4'd11)
            lookup = DIGITS[code[3:0]][8*(9-int'(r)) +: 8];
    endfunction

    always_ff @(posedge clk)
        data <= lookup(addr);

endmodule

// File: rtl/ascii_text_layer.sv
// Character-cell text overlay: COLS x ROWS buffer rendered through a 3-stage
// pixel pipeline, cleared to blanks after every reset.
module ascii_text_layer
    import text_layer_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int ROWS     = 4,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int SCALE    = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [6:0]              wr_char,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    output logic                    pixel_out,
    output logic                    pixel_valid,
    output logic                    busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int SH    = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int WIN_W = GLYPH_W * SCALE * COLS;
    localparam int WIN_H = GLYPH_H * SCALE * ROWS;

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_cnt;
    logic [6:0]       char_buf [CELLS];

    logic [9:0]       dx, dy;
    logic             in_win;
    logic             s1_on, s1_vid, s2_on, s2_vid, s3_on, s3_vid;
    logic [CW-1:0]    s1_col;
    logic [RW-1:0]    s1_row;
    logic [2:0]       s1_bit, s2_bit, s3_bit;
    logic [3:0]       s1_grow, s2_grow;
    logic [6:0]       s2_code;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic             wr_ok;
    logic [GLYPH_W-1:0] glyph_row;

    // FSM: state register, next-state, outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == AW'(CELLS - 1))
            state_nxt = RUN;
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    // Stage 1: window test and shift-based cell/glyph coordinates
    always_comb begin
        dx     = x - 10'(ORIGIN_X);
        dy     = y - 10'(ORIGIN_Y);
        in_win = int'(x) >= ORIGIN_X && int'(x) < ORIGIN_X + WIN_W &&
                 int'(y) >= ORIGIN_Y && int'(y) < ORIGIN_Y + WIN_H;
    end

    always_ff @(posedge clk) begin
        s1_col  <= CW'(dx >> (3 + SH));
        s1_bit  <= 3'(dx >> SH);
        s1_row  <= RW'(dy >> (4 + SH));
        s1_grow <= 4'(dy >> SH);
        s2_bit  <= s1_bit;
        s2_grow <= s1_grow;
        s3_bit  <= s2_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_on  <= 1'b0;
            s1_vid <= 1'b0;
            s2_on  <= 1'b0;
            s2_vid <= 1'b0;
            s3_on  <= 1'b0;
            s3_vid <= 1'b0;
        end else begin
            s1_on  <= in_win & video_on & ~busy;
            s1_vid <= video_on;
            s2_on  <= s1_on;
            s2_vid <= s1_vid;
            s3_on  <= s2_on;
            s3_vid <= s2_vid;
        end
    end

    // Stage 2: buffer read shares the edge with writes, so the read sees old data
    always_comb begin
        rd_addr = AW'(int'(s1_row) * COLS + int'(s1_col));
        wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
        wr_ok   = wr_en && !busy && int'(wr_col) < COLS && int'(wr_row) < ROWS;
    end

    always_ff @(posedge clk) begin
        if (busy)
            char_buf[clr_cnt] <= CHAR_BLANK;
        else if (wr_ok)
            char_buf[wr_addr] <= wr_char;
        s2_code <= char_buf[rd_addr];
    end

    // Stage 3: registered glyph fetch
    glyph_rom u_glyph_rom (
        .clk  (clk),
        .addr ({s2_code, s2_grow}),
        .data (glyph_row)
    );

    always_comb begin
        pixel_out   = s3_on & ~busy & glyph_row[3'd7 - s3_bit];
        pixel_valid = s3_vid;
    end

endmodule

// File: tb/tb_ascii_text_layer.sv
// Directed bench for ascii_text_layer: default geometry plus a SCALE=2 instance.
module tb_ascii_text_layer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_col = '0;
    logic [1:0] wr_row = '0;
    logic [6:0] wr_char = '0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       video_on = 1'b0;
    logic       pixel_out, pixel_valid, busy;
    logic       pixel_out2, pixel_valid2, busy2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ascii_text_layer #(.COLS(16), .ROWS(4), .ORIGIN_X(0), .ORIGIN_Y(0), .SCALE(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .x(x), .y(y), .video_on(video_on),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .busy(busy)
    );

    ascii_text_layer #(.COLS(16), .ROWS(4), .ORIGIN_X(0), .ORIGIN_Y(0), .SCALE(2)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .x(x), .y(y), .video_on(video_on),
        .pixel_out(pixel_out2), .pixel_valid(pixel_valid2), .busy(busy2)
    );

    task automatic write_cell(input logic [3:0] c, input logic [1:0] r, input logic [6:0] ch);
        wr_col  = c;
        wr_row  = r;
        wr_char = ch;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        video_on = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || pixel_valid !== 1'b0 || pixel_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b pix=%b, expected 1 0 0", busy, pixel_valid, pixel_out);
        end
        reset = 1'b0;
        n = 0;
        // a write to an already-cleared cell late in the clear must be dropped
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 40) begin
                wr_col = 4'd0; wr_row = 2'd0; wr_char = 7'h31; wr_en = 1'b1;
            end else
                wr_en = 1'b0;
        end
        wr_en = 1'b0;
        vectors++;
        if (n != 64) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, expected 64", n);
        end
        for (int i = 0; i < 128*64 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== 1'b0 || pixel_valid !== 1'b1 || pixel_out2 !== 1'b0) begin
                    errors++;
                    $display("FAIL blank_scan px=%0d: pix=%b valid=%b pix2=%b, expected 0 1 0",
                             i-3, pixel_out, pixel_valid, pixel_out2);
                end
            end
            if (i < 128*64) begin
                x = 10'(i % 128); y = 10'(i / 128); video_on = 1'b1;
            end else
                video_on = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_busy_write();
        for (int i = 0; i < 8 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_write x=%0d: got %b, expected 0", i-3, pixel_out);
                end
            end
            x = 10'(i); y = 10'd4; video_on = (i < 8);
            @(negedge clk);
        end
    endtask

    task automatic test_digit_zero();
        logic [7:0] exp_row;
        exp_row = 8'b0011_1000;
        write_cell(4'd0, 2'd0, 7'h30);
        for (int i = 0; i < 8 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== exp_row[7-(i-3)] || pixel_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL digit_zero x=%0d: pix=%b valid=%b, expected %b 1",
                             i-3, pixel_out, pixel_valid, exp_row[7-(i-3)]);
                end
            end
            x = 10'(i); y = 10'd2; video_on = (i < 8);
            @(negedge clk);
        end
    endtask

    task automatic test_non_digit();
        write_cell(4'd1, 2'd0, 7'h41);
        // x=8..15 inside cell 1, then x=128 just past the right edge
        for (int i = 0; i < 9 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== 1'b0 || pixel_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL non_digit px=%0d: pix=%b valid=%b, expected 0 1", i-3, pixel_out, pixel_valid);
                end
            end
            x = (i < 8) ? 10'(8 + i) : 10'd128; y = 10'd5; video_on = (i < 9);
            @(negedge clk);
        end
        // lit pixel of '0' with video_on low
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                vectors++;
                if (pixel_out !== 1'b0 || pixel_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL video_off: pix=%b valid=%b, expected 0 0", pixel_out, pixel_valid);
                end
            end
            x = 10'd3; y = 10'd2; video_on = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_read_first();
        logic [7:0] exp_row;
        // x=0,1 read '0' row 4 (01000100); x=2.. read '1' row 4 (00011000)
        exp_row = 8'b0101_1000;
        for (int i = 0; i < 8 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== exp_row[7-(i-3)]) begin
                    errors++;
                    $display("FAIL read_first x=%0d: got %b, expected %b", i-3, pixel_out, exp_row[7-(i-3)]);
                end
            end
            if (i == 2) begin
                wr_col = 4'd0; wr_row = 2'd0; wr_char = 7'h31; wr_en = 1'b1;
            end else
                wr_en = 1'b0;
            x = 10'(i); y = 10'd4; video_on = (i < 8);
            @(negedge clk);
        end
    endtask

    task automatic test_scale2();
        logic [15:0] exp_row;
        exp_row = 16'b0000_0011_1100_0000;
        for (int i = 0; i < 32 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out2 !== exp_row[15-((i-3) % 16)] || pixel_valid2 !== 1'b1) begin
                    errors++;
                    $display("FAIL scale2 y=%0d x=%0d: pix=%b valid=%b, expected %b 1", 4 + (i-3)/16,
                             (i-3) % 16, pixel_out2, pixel_valid2, exp_row[15-((i-3) % 16)]);
                end
            end
            x = 10'(i % 16); y = 10'(4 + i / 16); video_on = (i < 32);
            @(negedge clk);
        end
    endtask

    task automatic test_midframe_reset();
        int n;
        for (int i = 0; i < 10; i++) begin
            x = 10'(i % 8); y = 10'd2; video_on = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (pixel_valid !== 1'b0 || pixel_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset: valid=%b pix=%b busy=%b, expected 0 0 1", pixel_valid, pixel_out, busy);
        end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            vectors++;
            if (pixel_out !== 1'b0) begin
                errors++;
                $display("FAIL clear_pix n=%0d: got %b, expected 0", n, pixel_out);
            end
            x = 10'(n % 8); y = 10'd2; video_on = 1'b1;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 64) begin
            errors++;
            $display("FAIL reclear_cycles: got %0d, expected 64", n);
        end
        for (int i = 0; i < 8 + 3; i++) begin
            if (i >= 3) begin
                vectors++;
                if (pixel_out !== 1'b0 || pixel_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL recleared x=%0d: pix=%b valid=%b, expected 0 1", i-3, pixel_out, pixel_valid);
                end
            end
            x = 10'(i); y = 10'd2; video_on = (i < 8);
            @(negedge clk);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_busy_write();
        test_digit_zero();
        test_non_digit();
        test_read_first();
        test_scale2();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
